// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// radix-2 shift-add multiplier for MUL/MAC that stalls upstream until done.
module alu_exec_unit #(
  parameter int opSize  = 24,
  parameter int tagSize = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic               flush,
  input  logic [3:0]         aluOp,
  input  logic [opSize-1:0]  op1,
  input  logic [opSize-1:0]  op2,
  input  logic [opSize-1:0]  op3,
  input  logic [tagSize-1:0] tag_in,
  output logic [opSize-1:0]  result,
  output logic               zero,
  output logic               neg,
  output logic [tagSize-1:0] tag_out,
  output logic               result_valid,
  output logic               stall
);

  localparam int              cntW    = $clog2(opSize);
  localparam logic [cntW-1:0] lastCnt = cntW'(opSize - 1);
  localparam logic [5:0]      shLimit = 6'(opSize);

  typedef enum logic {IDLE, MUL} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [opSize-1:0]   r_mcand;
  logic [opSize-1:0]   r_mplier;
  logic [opSize-1:0]   r_acc;
  logic [cntW-1:0]     r_cnt;
  logic [tagSize-1:0]  r_tag;
  logic [opSize-1:0]   r_result;
  logic                r_zero;
  logic                r_neg;
  logic [tagSize-1:0]  r_tagOut;
  logic                r_resultValid;

  logic                w_stall;
  logic                w_isMul;
  logic                w_accept;
  logic                w_load;
  logic                w_mulDone;
  logic                w_write;
  logic [5:0]          w_shamt;
  logic [opSize-1:0]   w_aluRes;
  logic [opSize-1:0]   w_accNext;
  logic [opSize-1:0]   w_wrData;

  assign w_stall   = (r_state == MUL);
  assign w_isMul   = (aluOp == 4'd8) || (aluOp == 4'd9);
  assign w_accept  = valid_in & ~w_stall & ~flush;
  assign w_load    = w_accept & w_isMul;
  assign w_mulDone = w_stall && (r_cnt == lastCnt);
  assign w_shamt   = {1'b0, op2[4:0]};
  assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Flush wins over completion, so a finishing multiply is silently dropped.
  assign w_write   = ~flush & ((w_accept & ~w_isMul) | w_mulDone);
  assign w_wrData  = w_stall ? w_accNext : w_aluRes;

  always_comb begin
    w_aluRes = '0;
    case (aluOp)
      4'd0:    w_aluRes = op1 + op2;
      4'd1:    w_aluRes = op1 - op2;
      4'd2:    w_aluRes = op1 & op2;
      4'd3:    w_aluRes = op1 | op2;
      4'd4:    w_aluRes = op1 ^ op2;
      4'd5:    w_aluRes = (w_shamt >= shLimit) ? '0 : (op1 << w_shamt);
      4'd6:    w_aluRes = (w_shamt >= shLimit) ? '0 : (op1 >> w_shamt);
      4'd7:    w_aluRes = op3;
      default: w_aluRes = '0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_load) w_nextState = MUL;
      MUL:     if (w_mulDone) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (flush) w_nextState = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // The multiply engine keeps stepping on a flush cycle; that work is discarded
  // because the state returns to IDLE and the next load reinitialises it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_tag         <= '0;
      r_result      <= '0;
      r_zero        <= 1'b0;
      r_neg         <= 1'b0;
      r_tagOut      <= '0;
      r_resultValid <= 1'b0;
    end else begin
      r_resultValid <= w_write;
      if (w_write) begin
        r_result <= w_wrData;
        r_zero   <= (w_wrData == '0);
        r_neg    <= w_wrData[opSize-1];
        r_tagOut <= w_stall ? r_tag : tag_in;
      end
      if (w_load) begin
        r_mcand  <= op1;
        r_mplier <= op2;
        r_acc    <= (aluOp == 4'd9) ? op3 : '0;
        r_cnt    <= '0;
        r_tag    <= tag_in;
      end else if (w_stall) begin
        r_acc    <= w_accNext;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign result       = r_result;
  assign zero         = r_zero;
  assign neg          = r_neg;
  assign tag_out      = r_tagOut;
  assign result_valid = r_resultValid;
  assign stall        = w_stall;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a driver pushes expected results from an
// arithmetic reference model, and a negedge monitor pops and compares them.
module tb_alu_exec_unit;

  localparam int OPS = 24;

  typedef struct {
    logic [23:0] res;
    logic        z;
    logic        n;
    logic [3:0]  tag;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        flush;
  logic [3:0]  aluOp;
  logic [23:0] op1, op2, op3;
  logic [3:0]  tag_in;
  logic [23:0] result;
  logic        zero, neg;
  logic [3:0]  tag_out;
  logic        result_valid;
  logic        stall;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stallStart = 0;
  int          stallEnd = 0;
  int          resetAt = -1;
  logic        monOn = 1'b0;
  logic [29:0] lastExp = '0;
  exp_t        q[$];

  alu_exec_unit #(.opSize(24), .tagSize(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .aluOp(aluOp),
    .op1(op1), .op2(op2), .op3(op3), .tag_in(tag_in), .result(result),
    .zero(zero), .neg(neg), .tag_out(tag_out), .result_valid(result_valid),
    .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [23:0] refAlu(input logic [3:0] op, input logic [23:0] a, b, c);
    longint la, lb, lc, x;
    int sh;
    la = longint'(a); lb = longint'(b); lc = longint'(c);
    sh = int'(b[4:0]);
    case (op)
      4'd0: x = la + lb;
      4'd1: x = la - lb;
      4'd2: x = la & lb;
      4'd3: x = la | lb;
      4'd4: x = la ^ lb;
      4'd5: x = (sh >= OPS) ? 0 : (la << sh);
      4'd6: x = (sh >= OPS) ? 0 : (la >> sh);
      4'd7: x = lc;
      4'd8: x = la * lb;
      4'd9: x = la * lb + lc;
      default: x = 0;
    endcase
    return 24'(x);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drives one cycle of inputs and advances the model: acceptance, stall window, drops.
  task automatic applyStimulus(input logic [3:0] op, input logic [23:0] a, b, c,
                               input logic [3:0] t, input logic v, input logic fl,
                               input logic rs, output logic acc);
    int   k;
    logic busy;
    exp_t e;
    @(posedge clk); #1;
    rst = rs; valid_in = v; flush = fl; aluOp = op;
    op1 = a; op2 = b; op3 = c; tag_in = t;
    k = cyc;
    busy = (k >= stallStart) && (k < stallEnd);
    acc = 1'b0;
    if (rs || fl) begin
      while (q.size() > 0 && q[$].due > k) void'(q.pop_back());
      if (stallEnd > k + 1) stallEnd = k + 1;
      if (rs) resetAt = k + 1;
    end else if (v && !busy) begin
      acc   = 1'b1;
      e.res = refAlu(op, a, b, c);
      e.z   = (e.res == 24'd0);
      e.n   = e.res[23];
      e.tag = t;
      if (op == 4'd8 || op == 4'd9) begin
        e.due      = k + 1 + OPS;
        stallStart = k + 1;
        stallEnd   = k + 1 + OPS;
      end else begin
        e.due = k + 1;
      end
      q.push_back(e);
    end
  endtask

  task automatic sendOp(input logic [3:0] op, input logic [23:0] a, b, c, input logic [3:0] t);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      applyStimulus(op, a, b, c, t, 1'b1, 1'b0, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout op %0d: got no acceptance expected acceptance within 40 cycles", op);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) applyStimulus(4'd0, 24'd0, 24'd0, 24'd0, 4'd0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (cyc == resetAt) lastExp = '0;
      checkOutput("stall", {31'd0, stall}, {31'd0, (cyc >= stallStart) && (cyc < stallEnd)});
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++; errors++;
        $display("[TB] FAIL missing_result due cycle %0d: got no pulse expected result %h tag %h",
                 q[0].due, q[0].res, q[0].tag);
        void'(q.pop_front());
      end
      if (result_valid) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_valid at cycle %0d: got pulse with result %h expected no pulse",
                   cyc, result);
        end else begin
          exp_t e;
          e = q.pop_front();
          checkOutput("result", {2'b0, result, zero, neg, tag_out}, {2'b0, e.res, e.z, e.n, e.tag});
          lastExp = {e.res, e.z, e.n, e.tag};
        end
      end else begin
        checkOutput("hold", {2'b0, result, zero, neg, tag_out}, {2'b0, lastExp});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    rst = 1'b1; valid_in = 1'b1; flush = 1'b0; aluOp = 4'd0;
    op1 = 24'd5; op2 = 24'd6; op3 = 24'd0; tag_in = 4'd3;
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_outputs", {result_valid, stall, result, zero, neg, tag_out}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    lastExp = '0;
    monOn = 1'b1;

    // Back-to-back single-cycle ops including wrap, borrow and shift boundaries.
    sendOp(4'd0, 24'hFFFFFF, 24'h000001, 24'd0, 4'd1);
    sendOp(4'd1, 24'h000000, 24'h000001, 24'd0, 4'd2);
    sendOp(4'd5, 24'h000001, 24'd23, 24'd0, 4'd3);
    sendOp(4'd5, 24'h000001, 24'd24, 24'd0, 4'd4);
    sendOp(4'd6, 24'h800000, 24'd23, 24'd0, 4'd5);
    sendOp(4'd4, 24'h0F0F0F, 24'hFF00FF, 24'd0, 4'd6);
    sendOp(4'd7, 24'd0, 24'd0, 24'h123456, 4'd7);
    sendOp(4'd12, 24'h111111, 24'h222222, 24'd0, 4'd8);
    idle(2);

    sendOp(4'd9, 24'd3, 24'd5, 24'd7, 4'hA);
    idle(1);
    sendOp(4'd8, 24'h001000, 24'h001000, 24'd0, 4'hB);
    // Upstream keeps presenting ADD 2+2 while the multiplier stalls.
    sendOp(4'd8, 24'd6, 24'd7, 24'd0, 4'hC);
    sendOp(4'd0, 24'd2, 24'd2, 24'd0, 4'hD);
    idle(2);

    sendOp(4'd8, 24'd7, 24'd9, 24'd0, 4'h5);
    idle(9);
    applyStimulus(4'd0, 24'd0, 24'd0, 24'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(4'd0, 24'd1, 24'd1, 24'd0, 4'h6, 1'b1, 1'b1, 1'b0, acc);
    idle(3);

    sendOp(4'd9, 24'd11, 24'd13, 24'd2, 4'h9);
    idle(5);
    applyStimulus(4'd0, 24'd1, 24'd1, 24'd0, 4'h1, 1'b1, 1'b0, 1'b1, acc);
    idle(1);
    @(negedge clk);
    checkOutput("reset_midop", {result_valid, stall, result, zero, neg, tag_out}, 32'd0);
    idle(30);

    for (int i = 0; i < 80; i++) begin
      logic [3:0]  op;
      logic [23:0] a, b, c;
      op = 4'($urandom_range(0, 15));
      if ((op == 4'd8 || op == 4'd9) && $urandom_range(0, 2) != 0) op = 4'($urandom_range(0, 7));
      a = 24'($urandom);
      b = (op == 4'd5 || op == 4'd6) ? 24'($urandom_range(0, 31)) : 24'($urandom);
      c = 24'($urandom);
      if ($urandom_range(0, 19) == 0)
        applyStimulus(op, a, b, c, 4'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0, acc);
      if ($urandom_range(0, 4) == 0) idle(1);
      sendOp(op, a, b, c, 4'($urandom));
    end

    idle(30);
    checkOutput("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic unit that consumes the three selected operands (op1, op2, op3) produced by the ALU operand/forwarding selection stage, and registers a result for the EX/MEM boundary. Single-cycle ops (add, sub, logic, shifts, pass) complete in one clock. MUL and MAC run an iterative radix-2 shift-add engine and stall the pipeline until done. A flush input aborts in-flight work on branch redirect.

## Interface
- opSize, 24, operand/result width in bits
- tagSize, 4, destination-register tag width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  operand bundle on op1/op2/op3/aluOp/tag_in is valid this cycle
- flush  in  1  discard any accepted or in-flight op
- aluOp  in  4  operation select (encoding below)
- op1, op2, op3  in  opSize  operands from the operand-select stage
- tag_in  in  tagSize  destination tag travelling with the op
- result  out  opSize  registered result
- zero  out  1  registered: result == 0
- neg  out  1  registered: result[opSize-1]
- tag_out  out  tagSize  tag of the op that produced result
- result_valid  out  1  one-cycle pulse, result/flags/tag_out valid
- stall  out  1  combinational; high while state == MUL; upstream must hold its bundle

## Operation
- aluOp: 0 ADD op1+op2; 1 SUB op1-op2; 2 AND; 3 OR; 4 XOR; 5 SLL op1<<op2[4:0]; 6 SRL (logical) op1>>op2[4:0]; 7 PASS op3; 8 MUL op1*op2; 9 MAC op1*op2+op3; 10-15 result 0 (still valid).
- All arithmetic is modulo 2^opSize. Carries and upper product bits are dropped.
- Shift amount >= opSize gives 0.
- States: IDLE, MUL.
- Accept condition: valid_in & ~stall & ~flush.
- IDLE + accepted single-cycle op: result, flags, and tag_out are written; result_valid = 1 next cycle.
- IDLE + accepted MUL/MAC: load mcand = op1, mplier = op2, acc = (MAC ? op3 : 0), cnt = 0, latch tag; go to MUL. result_valid = 0.
- MUL, each edge:
  - if mplier[0], acc += mcand
  - mcand <<= 1; mplier >>= 1; cnt++
  - on the edge where cnt reaches opSize-1, write result = updated acc plus flags and tag_out, pulse result_valid, go to IDLE.
- valid_in while stall = 1 is ignored. Upstream re-presents the bundle, which is accepted in the first cycle after stall drops.
- flush: forces IDLE, clears result_valid, and writes nothing. In-flight MUL/MAC is dropped. Flush in the same cycle as valid_in means nothing is accepted. Flush has priority over completion in the same cycle.
- result, zero, neg, tag_out hold their last values when result_valid = 0.

## Timing
- Reset values: result = 0, zero = 0, neg = 0, tag_out = 0, result_valid = 0, stall = 0, state = IDLE, cnt = 0.
- rst mid-MUL: returns to IDLE on that edge and no result is produced. rst has priority over flush and valid_in.
- Single-cycle latency: accepted at edge E0, result_valid high in the cycle after E0.
- MUL/MAC latency: accepted at E0, iterations on E1..E(opSize), result_valid high after E(opSize).
  - stall high in the cycles after E0 through the cycle before E(opSize).
  - opSize-cycle occupancy (24 at default).
- Back-to-back: a new op can be accepted in the same cycle result_valid is high, giving 1 result/cycle for single-cycle ops.
- result_valid is never high for two cycles from a single op.

## Test plan
- Reset: assert rst for 2 cycles with valid_in = 1 and aluOp = ADD. All outputs are 0 and result_valid stays 0 throughout.
- Single-cycle ops:
  - ADD 0xFFFFFF + 0x000001 gives result 0, zero = 1, neg = 0.
  - SUB 0 - 1 gives 0xFFFFFF, neg = 1.
  - SLL 1 << 23 gives 0x800000.
  - SLL by 24 gives 0.
  - Each result_valid arrives exactly 1 cycle after valid_in, and back-to-back ops produce back-to-back pulses.
- MAC: op1 = 3, op2 = 5, op3 = 7, tag_in = 0xA.
  - stall is high for 24 cycles; result = 22, tag_out = 0xA.
  - result_valid is a single pulse exactly 24 cycles after acceptance.
  - MUL 0x001000 * 0x001000 gives 0x000000 (overflow truncated), zero = 1.
- Stall hold: hold valid_in = 1 with ADD 2+2 during a MUL. The ADD is ignored until stall falls, then accepted once, giving result 4 one cycle after MUL's result_valid.
- Flush: flush at iteration 10 of MUL 7*9. No result_valid, returns to IDLE, result keeps its prior value. Also assert flush together with valid_in ADD 1+1: nothing is accepted.
- Reset mid-op: rst at iteration 5 of MAC. stall drops the next cycle, all outputs are 0, and no result_valid pulse occurs.
